// File: rtl/elastic_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : elastic_pipe_stage
// Description : DEPTH-entry in-order elastic buffer between two CPU pipeline
//               stages with valid/allow interlock, ready_go stall and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module elastic_pipe_stage #(
  parameter int                DATA_W    = 64,
  parameter int                CSR_W     = 32,
  parameter int                DEPTH     = 2,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter logic [DATA_W-1:0] NOP_VAL   = '0,
  parameter bit                HOLD_OUT  = 1'b0,
  localparam int               c_CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               valid_in,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               exc_in,
  input  logic [CSR_W-1:0]   csr_in,
  output logic               allow_out,
  input  logic               ready_go,
  output logic               valid_out,
  output logic [DATA_W-1:0]  data_out,
  output logic               exc_out,
  output logic [CSR_W-1:0]   csr_out,
  input  logic               allow_in,
  input  logic               flush,
  output logic [c_CNT_W-1:0] count
);

  localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);
  localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

  logic [DATA_W-1:0]  r_data [DEPTH];
  logic [CSR_W-1:0]   r_csr  [DEPTH];
  logic               r_exc  [DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic w_empty;
  logic w_deq;
  logic w_enq;

  assign w_empty   = (r_count == '0);
  assign valid_out = ~w_empty & ready_go;
  assign w_deq     = valid_out & allow_in;
  assign allow_out = (r_count < c_FULL) | w_deq;
  assign w_enq     = valid_in & allow_out & ~flush & aresetn;
  assign count     = r_count;

  // Head storage stays visible while stalled; empty stage shows a bubble.
  assign data_out = (~w_empty || HOLD_OUT) ? r_data[r_rd_ptr] : NOP_VAL;
  assign exc_out  = ~w_empty & r_exc[r_rd_ptr];
  assign csr_out  = w_empty ? '0 : r_csr[r_rd_ptr];

  always_ff @(posedge aclk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!aresetn || (flush && i == 0)) begin
        r_data[i] <= RESET_VAL;
        r_csr[i]  <= '0;
        r_exc[i]  <= 1'b0;
      end else if (w_enq && r_wr_ptr == c_PTR_W'(i)) begin
        // An excepting item keeps its message but not its payload.
        r_data[i] <= exc_in ? RESET_VAL : data_in;
        r_csr[i]  <= csr_in;
        r_exc[i]  <= exc_in;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_deq) begin
        r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
      end
      if (w_enq) begin
        r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
      end
      if (w_enq && !w_deq) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (w_deq && !w_enq) begin
        r_count <= r_count - c_CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
